sram_read_arbiter: RTL and testbench



---
 rtl/arcade_mem_pkg.sv | 11 +
 rtl/sram_poll_timer.sv | 36 +++
 rtl/sram_read_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sram_read_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_mem_pkg.sv
// rtl/arcade_mem_pkg.sv - shared types and constants for the arcade external SRAM read path
package arcade_mem_pkg;

  localparam int SRAM_AW = 21;
  localparam int SRAM_DW = 8;
  localparam logic [SRAM_AW-1:0] CFG_ADDR_DEFAULT = 21'h08FD5;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} arb_state_e;
  typedef enum logic [1:0] {OWN_A, OWN_B, OWN_CFG} owner_e;

endpackage

// File: rtl/sram_poll_timer.sv
// rtl/sram_poll_timer.sv - free-running poll period counter with sticky poll_pending flag
module sram_poll_timer #(
  parameter int unsigned POLL_PERIOD = 65536
) (
  input  logic clk_24M,
  input  logic reset,
  input  logic poll_clear_i,
  output logic poll_pending_o
);

  localparam int unsigned TW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;

  logic [TW-1:0] timer_q, timer_d;
  logic          pending_q, pending_d;
  logic          wrap;

  // A wrap in the same cycle as a clear keeps the request alive.
  always_comb begin
    wrap      = (timer_q == TW'(POLL_PERIOD - 1));
    timer_d   = wrap ? '0 : timer_q + TW'(1);
    pending_d = wrap | (pending_q & ~poll_clear_i);
  end

  always_ff @(posedge clk_24M) begin
    if (reset) begin
      timer_q   <= '0;
      pending_q <= 1'b1;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  assign poll_pending_o = pending_q;

endmodule

// File: rtl/sram_read_arbiter.sv
// rtl/sram_read_arbiter.sv - shares the read-only SRAM between ports A, B and the config poller
module sram_read_arbiter
  import arcade_mem_pkg::*;
#(
  parameter int unsigned        WAIT_CYCLES = 2,
  parameter int unsigned        POLL_PERIOD = 65536,
  parameter logic [SRAM_AW-1:0] CFG_ADDR    = CFG_ADDR_DEFAULT,
  parameter logic [1:0]         CFG_DEFAULT = 2'b00
) (
  input  logic               clk_24M,
  input  logic               reset,
  input  logic               a_req,
  input  logic [SRAM_AW-1:0] a_addr,
  output logic               a_ack,
  output logic [SRAM_DW-1:0] a_data,
  input  logic               b_req,
  input  logic [SRAM_AW-1:0] b_addr,
  output logic               b_ack,
  output logic [SRAM_DW-1:0] b_data,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [SRAM_DW-1:0] sram_data,
  output logic               sram_we_n,
  output logic [1:0]         scandblctrl,
  output logic               cfg_valid
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  arb_state_e         state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [SRAM_DW-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
  logic               a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [1:0]         scb_q, scb_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic               last_b_q, last_b_d;
  logic               grant;
  logic               poll_pending;
  logic               poll_clear;

  sram_poll_timer #(
    .POLL_PERIOD(POLL_PERIOD)
  ) u_poll_timer (
    .clk_24M       (clk_24M),
    .reset         (reset),
    .poll_clear_i  (poll_clear),
    .poll_pending_o(poll_pending)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    a_data_d    = a_data_q;
    b_data_d    = b_data_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    scb_d       = scb_q;
    cfg_valid_d = cfg_valid_q;
    last_b_d    = last_b_q;
    grant       = 1'b1;
    poll_clear  = 1'b0;

    case (state_q)
      IDLE: begin
        // Poller first; on an A/B tie the port not served last time wins.
        if (poll_pending) begin
          owner_d = OWN_CFG;
          addr_d  = CFG_ADDR;
        end else if (a_req && (!b_req || last_b_q)) begin
          owner_d = OWN_A;
          addr_d  = a_addr;
        end else if (b_req) begin
          owner_d = OWN_B;
          addr_d  = b_addr;
        end else begin
          grant  = 1'b0;
          addr_d = CFG_ADDR;
        end
        if (grant) begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (cnt_q == 4'd0) begin
          case (owner_q)
            OWN_A: begin
              a_data_d = sram_data;
              a_ack_d  = 1'b1;
            end
            OWN_B: begin
              b_data_d = sram_data;
              b_ack_d  = 1'b1;
            end
            default: scb_d = sram_data[1:0];
          endcase
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
        case (owner_q)
          OWN_A:   last_b_d = 1'b0;
          OWN_B:   last_b_d = 1'b1;
          default: begin
            poll_clear  = 1'b1;
            cfg_valid_d = 1'b1;
          end
        endcase
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_24M) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CFG;
      cnt_q       <= '0;
      addr_q      <= CFG_ADDR;
      a_data_q    <= '0;
      b_data_q    <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      scb_q       <= CFG_DEFAULT;
      cfg_valid_q <= 1'b0;
      last_b_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      a_data_q    <= a_data_d;
      b_data_q    <= b_data_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      scb_q       <= scb_d;
      cfg_valid_q <= cfg_valid_d;
      last_b_q    <= last_b_d;
    end
  end

  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign a_data      = a_data_q;
  assign b_data      = b_data_q;
  assign sram_addr   = addr_q;
  assign sram_we_n   = 1'b1;
  assign scandblctrl = scb_q;
  assign cfg_valid   = cfg_valid_q;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// tb/tb_sram_read_arbiter.sv - self-checking bench for sram_read_arbiter
module tb_sram_read_arbiter;

  localparam int W = 2;
  localparam int P = 64;
  localparam logic [20:0] CFGA = 21'h08FD5;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, b_req;
  logic [20:0] a_addr, b_addr;
  logic        a_ack, b_ack;
  logic [7:0]  a_data, b_data;
  logic [20:0] sram_addr, sram_addr16;
  logic [7:0]  sram_data, sram_data16;
  logic        sram_we_n, sram_we_n16;
  logic [1:0]  scb, scb16;
  logic        cfg_valid, cfg_valid16;
  logic        a_ack16, b_ack16;
  logic [7:0]  a_data16, b_data16;
  logic [7:0]  cfg_byte, cfg_byte16;

  int n_vec = 0;
  int n_bad = 0;
  int tcyc  = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [20:0] addr, input logic [7:0] cfgb);
    if (addr == CFGA) return cfgb;
    if (addr == 21'h00100) return 8'hA5;
    return addr[7:0] ^ addr[15:8] ^ {3'b000, addr[20:16]} ^ 8'h5A;
  endfunction

  assign sram_data   = mem(sram_addr, cfg_byte);
  assign sram_data16 = mem(sram_addr16, cfg_byte16);

  sram_read_arbiter #(.WAIT_CYCLES(W), .POLL_PERIOD(P)) dut (
    .clk_24M(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_data(a_data),
    .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_data(b_data),
    .sram_addr(sram_addr), .sram_data(sram_data), .sram_we_n(sram_we_n),
    .scandblctrl(scb), .cfg_valid(cfg_valid)
  );

  sram_read_arbiter #(.WAIT_CYCLES(W), .POLL_PERIOD(16)) dut16 (
    .clk_24M(clk), .reset(reset),
    .a_req(1'b0), .a_addr(21'h0), .a_ack(a_ack16), .a_data(a_data16),
    .b_req(1'b0), .b_addr(21'h0), .b_ack(b_ack16), .b_data(b_data16),
    .sram_addr(sram_addr16), .sram_data(sram_data16), .sram_we_n(sram_we_n16),
    .scandblctrl(scb16), .cfg_valid(cfg_valid16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle index since the last reset-state cycle (0 = reset state).
  always @(posedge clk) begin
    if (reset) tcyc <= 0;
    else       tcyc <= tcyc + 1;
  end

  // Transaction-level reference model: each access occupies W+2 cycles from grant.
  bit          prev_rst = 1'b0, m_on = 1'b0;
  int          m_cyc, m_done, m_owner;
  bit          m_pend, m_busy, m_last_b, m_cfgv, e_a_ack, e_b_ack;
  logic [20:0] m_gaddr, m_addr_next, e_addr;
  logic [7:0]  m_gdata, e_a_data, e_b_data;
  logic [1:0]  e_scb;

  always @(negedge clk) begin
    if (prev_rst) begin
      m_on = 1'b1; m_cyc = 0; m_pend = 1'b1; m_busy = 1'b0; m_last_b = 1'b1; m_cfgv = 1'b0;
      e_a_data = 8'h00; e_b_data = 8'h00; e_scb = 2'b00; e_addr = CFGA; m_addr_next = CFGA;
      e_a_ack = 1'b0; e_b_ack = 1'b0;
    end else if (m_on) begin
      m_cyc++;
      e_a_ack = 1'b0;
      e_b_ack = 1'b0;
      e_addr  = m_addr_next;
      if (m_busy && m_cyc == m_done) begin
        if (m_owner == 0) begin e_a_ack = 1'b1; e_a_data = m_gdata; m_last_b = 1'b0; end
        else if (m_owner == 1) begin e_b_ack = 1'b1; e_b_data = m_gdata; m_last_b = 1'b1; end
        else e_scb = m_gdata[1:0];
      end
      if (m_busy && m_cyc == m_done + 1) begin
        m_busy = 1'b0;
        if (m_owner == 2) begin m_cfgv = 1'b1; m_pend = 1'b0; end
      end
      if (m_cyc % P == 0) m_pend = 1'b1;
    end
    if (m_on) begin
      chk("m.a_ack", 32'(a_ack), 32'(e_a_ack));
      chk("m.b_ack", 32'(b_ack), 32'(e_b_ack));
      chk("m.a_data", 32'(a_data), 32'(e_a_data));
      chk("m.b_data", 32'(b_data), 32'(e_b_data));
      chk("m.scandblctrl", 32'(scb), 32'(e_scb));
      chk("m.cfg_valid", 32'(cfg_valid), 32'(m_cfgv));
      chk("m.sram_addr", 32'(sram_addr), 32'(e_addr));
      chk("m.sram_we_n", 32'(sram_we_n), 32'd1);
      if (!reset) begin
        if (!m_busy) begin
          m_owner = -1;
          if (m_pend) begin m_owner = 2; m_gaddr = CFGA; end
          else if (a_req && b_req) begin
            m_owner = m_last_b ? 0 : 1;
            m_gaddr = m_last_b ? a_addr : b_addr;
          end
          else if (a_req) begin m_owner = 0; m_gaddr = a_addr; end
          else if (b_req) begin m_owner = 1; m_gaddr = b_addr; end
          if (m_owner >= 0) begin
            m_busy = 1'b1;
            m_done = m_cyc + W + 1;
            m_addr_next = m_gaddr;
          end else begin
            m_addr_next = CFGA;
          end
        end else if (m_cyc == m_done - 1) begin
          m_gdata = mem(m_gaddr, cfg_byte);
        end
      end
    end
    prev_rst = reset;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_safe();
    int n = 0;
    step();
    while (!((tcyc % P) >= 8 && (tcyc % P) <= 30) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("wait_safe bound", 32'(n), 32'd0);
  endtask

  typedef struct {
    bit          a;
    logic [20:0] aa;
    bit          b;
    logic [20:0] ba;
    int          a_off;
    int          b_off;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int c, got_a, got_b, nack, found;
    int seq_off[4];
    int seq_port[4];
    logic [20:0] sa;

    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, got_a, got_b, nack, found;
    int seq_off[4];
    int seq_port[4];
    logic [20:0] sa;

    tbl[0] = '{1'b1, 21'h00100,  1'b0, 21'h00000, 3, -1};
    tbl[1] = '{1'b0, 21'h00000,  1'b1, 21'h12345, -1, 3};
    tbl[2] = '{1'b1, 21'h00010,  1'b1, 21'h00020, 3, 7};
    tbl[3] = '{1'b1, 21'h1FFFFF, 1'b1, 21'h00000, 3, 7};
    tbl[4] = '{1'b1, 21'h0ABCD,  1'b0, 21'h00000, 3, -1};
    tbl[5] = '{1'b1, 21'h00F0F,  1'b1, 21'h1F00F, 7, 3};
    tbl[6] = '{1'b0, 21'h00000,  1'b1, 21'h08FD5, -1, 3};

    reset = 1'b1; a_req = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0;
    cfg_byte = 8'h03; cfg_byte16 = 8'h01;
    repeat (3) step();
    reset = 1'b0;

    // Reset state, then the first poll.
    chk("rst cfg_valid", 32'(cfg_valid), 32'd0);
    chk("rst scandblctrl", 32'(scb), 32'd0);
    chk("rst sram_addr", 32'(sram_addr), 32'(CFGA));
    chk("rst a_data", 32'(a_data), 32'd0);
    while (tcyc < 4) step();
    chk("poll0 scandblctrl", 32'(scb), 32'h3);
    chk("poll0 cfg_valid", 32'(cfg_valid), 32'd1);
    chk("poll0 sram_addr park", 32'(sram_addr), 32'(CFGA));
    chk("p16 first poll", 32'(scb16), 32'h1);

    // Config byte change picked up by the next poll of the short-period instance.
    cfg_byte16 = 8'h02;
    found = 0;
    for (int k = 0; k < 16 + W + 2 && found == 0; k++) begin
      step();
      if (scb16 == 2'b10) found = 1;
    end
    chk("p16 scandblctrl update", 32'(found), 32'd1);
    chk("p16 cfg_valid", 32'(cfg_valid16), 32'd1);

    // Directed vectors, each started from an idle arbiter with no poll pending.
    for (int i = 0; i < 7; i++) begin
      wait_safe();
      c = tcyc;
      a_req = tbl[i].a; a_addr = tbl[i].aa;
      b_req = tbl[i].b; b_addr = tbl[i].ba;
      got_a = -1; got_b = -1;
      for (int k = 0; k < 12; k++) begin
        step();
        if (a_ack) begin if (got_a < 0) got_a = tcyc - c; a_req = 1'b0; end
        if (b_ack) begin if (got_b < 0) got_b = tcyc - c; b_req = 1'b0; end
      end
      chk($sformatf("tbl%0d a_ack offset", i), 32'(got_a), 32'(tbl[i].a_off));
      chk($sformatf("tbl%0d b_ack offset", i), 32'(got_b), 32'(tbl[i].b_off));
      if (tbl[i].a) chk($sformatf("tbl%0d a_data", i), 32'(a_data), 32'(mem(tbl[i].aa, cfg_byte)));
      if (tbl[i].b) chk($sformatf("tbl%0d b_data", i), 32'(b_data), 32'(mem(tbl[i].ba, cfg_byte)));
    end

    // Both ports held: grants alternate A,B,A,B every W+2 cycles.
    wait_safe();
    c = tcyc; nack = 0;
    a_req = 1'b1; a_addr = 21'h00200;
    b_req = 1'b1; b_addr = 21'h00300;
    for (int k = 0; k < 20; k++) begin
      step();
      if ((a_ack || b_ack) && nack < 4) begin
        seq_off[nack] = tcyc - c;
        seq_port[nack] = a_ack ? 0 : 1;
        chk($sformatf("hold ack%0d data", nack), 32'(a_ack ? a_data : b_data),
            32'(mem(a_ack ? a_addr : b_addr, cfg_byte)));
        nack++;
        if (nack == 4) begin a_req = 1'b0; b_req = 1'b0; end
      end
    end
    chk("hold ack count", 32'(nack), 32'd4);
    for (int i = 0; i < 4 && i < nack; i++) begin
      chk($sformatf("hold ack%0d port", i), 32'(seq_port[i]), 32'(i % 2));
      chk($sformatf("hold ack%0d offset", i), 32'(seq_off[i]), 32'(3 + 4 * i));
    end

    // Timer wraps while A is in WAIT: poll slots in before the waiting B.
    while ((tcyc % P) != P - 2) step();
    c = tcyc;
    a_req = 1'b1; a_addr = 21'h00400;
    got_a = -1; got_b = -1; sa = '0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (tcyc == c + 1) begin b_req = 1'b1; b_addr = 21'h00500; end
      if (tcyc == c + 5) sa = sram_addr;
      if (a_ack) begin if (got_a < 0) got_a = tcyc - c; a_req = 1'b0; end
      if (b_ack) begin if (got_b < 0) got_b = tcyc - c; b_req = 1'b0; end
    end
    chk("wrap a_ack offset", 32'(got_a), 32'd3);
    chk("wrap poll addr", 32'(sa), 32'(CFGA));
    chk("wrap b_ack offset", 32'(got_b), 32'd11);

    // Reset during the WAIT of a B access.
    wait_safe();
    b_req = 1'b1; b_addr = 21'h00600;
    step();
    reset = 1'b1; b_req = 1'b0;
    step();
    reset = 1'b0;
    chk("midrst b_ack", 32'(b_ack), 32'd0);
    chk("midrst b_data", 32'(b_data), 32'd0);
    chk("midrst sram_addr", 32'(sram_addr), 32'(CFGA));
    nack = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (b_ack) nack++;
    end
    chk("midrst no b_ack", 32'(nack), 32'd0);

    // Randomised traffic checked against the model every cycle.
    for (int k = 0; k < 1500; k++) begin
      step();
      if (a_req) begin
        if (a_ack && $urandom_range(0, 3) != 0) a_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        a_req = 1'b1; a_addr = 21'($urandom);
      end
      if (b_req) begin
        if (b_ack && $urandom_range(0, 3) != 0) b_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        b_req = 1'b1;
        b_addr = ($urandom_range(0, 15) == 0) ? CFGA : 21'($urandom);
      end
      if ($urandom_range(0, 199) == 0) cfg_byte = 8'($urandom);
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
